controlador_turnos: RTL and testbench

- Turn-timing and scoring scheduler for the two-player memory game.
- Sits beside the main game FSM and owns three things: the per-turn countdown, which player holds the turn, and each player's pair count.
- Generates the `tiempo_terminado` pulse the FSM consumes. Resolves the winner code once all pairs are found.
- The FSM drives it with `iniciar` and with `par_valido`/`es_pareja` after each two-card evaluation.

---
 rtl/controlador_turnos.sv | 137 +++++++++++++
 tb/tb_controlador_turnos.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_turnos.sv
// Turn countdown, turn ownership and pair scoring for the two-player memory game.
// Sits beside the game FSM: emits tiempo_terminado and resolves the winner.
module controlador_turnos #(
  parameter int TICKS_POR_SEG = 50_000_000,
  parameter int SEG_TURNO     = 15,
  parameter int NUM_PAREJAS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iniciar,
  input  logic       pausa,
  input  logic       par_valido,
  input  logic       es_pareja,
  output logic       tiempo_terminado,
  output logic       jugador_actual,
  output logic [3:0] puntos_j1,
  output logic [3:0] puntos_j2,
  output logic [4:0] segundos_restantes,
  output logic       juego_terminado,
  output logic [1:0] ganador
);

  localparam int PW =
    (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_POR_SEG - 1);
  localparam logic [4:0]    SEG  = 5'(SEG_TURNO);
  localparam logic [3:0]    NP4  = 4'(NUM_PAREJAS);
  localparam logic [4:0]    NP5  = 5'(NUM_PAREJAS);

  typedef enum logic [1:0] {
    IDLE,
    CUENTA,
    FIN
  } estado_t;

  estado_t       estado, estado_n;
  logic [PW-1:0] presc, presc_n;
  logic          tt_n;
  logic          jug_n;
  logic [3:0]    p1_n, p2_n;
  logic [4:0]    seg_n;
  logic          fin_n;
  logic [1:0]    gan_n;
  logic [4:0]    suma;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado             <= IDLE;
      presc              <= '0;
      tiempo_terminado   <= 1'b0;
      jugador_actual     <= 1'b0;
      puntos_j1          <= '0;
      puntos_j2          <= '0;
      segundos_restantes <= '0;
      juego_terminado    <= 1'b0;
      ganador            <= 2'b00;
    end else begin
      estado             <= estado_n;
      presc              <= presc_n;
      tiempo_terminado   <= tt_n;
      jugador_actual     <= jug_n;
      puntos_j1          <= p1_n;
      puntos_j2          <= p2_n;
      segundos_restantes <= seg_n;
      juego_terminado    <= fin_n;
      ganador            <= gan_n;
    end
  end

  always_comb begin
    estado_n = estado;
    presc_n  = presc;
    tt_n     = 1'b0;
    jug_n    = jugador_actual;
    p1_n     = puntos_j1;
    p2_n     = puntos_j2;
    seg_n    = segundos_restantes;
    fin_n    = juego_terminado;
    gan_n    = ganador;
    suma     = '0;

    if (iniciar) begin
      estado_n = CUENTA;
      presc_n  = '0;
      jug_n    = 1'b0;
      p1_n     = '0;
      p2_n     = '0;
      seg_n    = SEG;
      fin_n    = 1'b0;
      gan_n    = 2'b00;
    end else begin
      unique case (estado)
        CUENTA: begin
          // An evaluation always wins over a coincident expiry tick
          if (par_valido) begin
            presc_n = '0;
            seg_n   = SEG;
            if (es_pareja) begin
              if (!jugador_actual && puntos_j1 != NP4)
                p1_n = puntos_j1 + 4'd1;
              if (jugador_actual && puntos_j2 != NP4)
                p2_n = puntos_j2 + 4'd1;
              suma = {1'b0, p1_n} + {1'b0, p2_n};
              if (suma == NP5) begin
                estado_n = FIN;
                seg_n    = '0;
                fin_n    = 1'b1;
                unique case (1'b1)
                  (p1_n > p2_n): gan_n = 2'b01;
                  (p2_n > p1_n): gan_n = 2'b10;
                  default:       gan_n = 2'b11;
                endcase
              end
            end else begin
              jug_n = ~jugador_actual;
            end
          end else if (!pausa) begin
            if (presc == PMAX) begin
              presc_n = '0;
              if (segundos_restantes > 5'd1) begin
                seg_n = segundos_restantes - 5'd1;
              end else begin
                tt_n  = 1'b1;
                jug_n = ~jugador_actual;
                seg_n = SEG;
              end
            end else begin
              presc_n = presc + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_turnos.sv
// Scoreboard bench for controlador_turnos: a cycle-count reference model
// queues expected outputs, a monitor pops and compares after each edge.
module tb_controlador_turnos;

  localparam int T  = 4;
  localparam int S  = 3;
  localparam int NP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iniciar = 1'b0;
  logic       pausa = 1'b0;
  logic       par_valido = 1'b0;
  logic       es_pareja = 1'b0;
  logic       tiempo_terminado;
  logic       jugador_actual;
  logic [3:0] puntos_j1;
  logic [3:0] puntos_j2;
  logic [4:0] segundos_restantes;
  logic       juego_terminado;
  logic [1:0] ganador;

  controlador_turnos #(
    .TICKS_POR_SEG(T),
    .SEG_TURNO(S),
    .NUM_PAREJAS(NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iniciar(iniciar),
    .pausa(pausa),
    .par_valido(par_valido),
    .es_pareja(es_pareja),
    .tiempo_terminado(tiempo_terminado),
    .jugador_actual(jugador_actual),
    .puntos_j1(puntos_j1),
    .puntos_j2(puntos_j2),
    .segundos_restantes(segundos_restantes),
    .juego_terminado(juego_terminado),
    .ganador(ganador)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tt;
    logic       jug;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [4:0] seg;
    logic       fin;
    logic [1:0] gan;
  } obs_t;

  obs_t sb[$];
  int tests = 0;
  int fails = 0;

  // Reference model: time spent in the turn counted in unpaused cycles
  bit       m_run, m_fin;
  int       m_p1, m_p2, m_jug, m_cyc;
  bit [1:0] m_gan;

  function automatic obs_t actual();
    return {tiempo_terminado, jugador_actual, puntos_j1, puntos_j2,
            segundos_restantes, juego_terminado, ganador};
  endfunction

  function automatic void model_reset();
    m_run = 0; m_fin = 0; m_p1 = 0; m_p2 = 0;
    m_jug = 0; m_cyc = 0; m_gan = 0;
  endfunction

  function automatic obs_t model_out(bit pulse);
    obs_t o;
    int s;
    s = m_fin ? 0 : (m_run ? S - m_cyc / T : 0);
    o.tt  = pulse;
    o.jug = m_jug[0];
    o.p1  = 4'(m_p1);
    o.p2  = 4'(m_p2);
    o.seg = 5'(s);
    o.fin = m_fin;
    o.gan = m_gan;
    return o;
  endfunction

  function automatic void report(string name, obs_t got, obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got tt=%0b jug=%0b p1=%0d p2=%0d seg=%0d fin=%0b gan=%b, need tt=%0b jug=%0b p1=%0d p2=%0d seg=%0d fin=%0b gan=%b",
               name, got.tt, got.jug, got.p1, got.p2, got.seg, got.fin,
               got.gan, exp.tt, exp.jug, exp.p1, exp.p2, exp.seg,
               exp.fin, exp.gan);
    end
  endfunction

  task automatic step(bit i, bit p, bit v, bit e);
    bit pulse;
    @(negedge clk);
    iniciar = i; pausa = p; par_valido = v; es_pareja = e;
    pulse = 0;
    if (i) begin
      model_reset();
      m_run = 1;
    end else if (m_run && !m_fin) begin
      if (v) begin
        m_cyc = 0;
        if (e) begin
          if (m_jug == 0) m_p1 = (m_p1 < NP) ? m_p1 + 1 : NP;
          else            m_p2 = (m_p2 < NP) ? m_p2 + 1 : NP;
          if (m_p1 + m_p2 == NP) begin
            m_fin = 1;
            m_gan = (m_p1 > m_p2) ? 2'b01 :
                    (m_p2 > m_p1) ? 2'b10 : 2'b11;
          end
        end else begin
          m_jug ^= 1;
        end
      end else if (!p) begin
        m_cyc++;
        if (m_cyc == S * T) begin
          pulse = 1;
          m_jug ^= 1;
          m_cyc = 0;
        end
      end
    end
    sb.push_back(model_out(pulse));
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic hit(int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && sb.size() > 0) report("cycle", actual(), sb.pop_front());
  end

  initial begin
    obs_t zero;
    zero = '0;
    model_reset();
    // reset then idle
    repeat (2) @(posedge clk);
    #1 report("reset_hold", actual(), zero);
    @(negedge clk) rst = 1'b1;
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    idle(3);

    // turn expiry
    step(1, 0, 0, 0);
    idle(14);

    // match at seg 2, then miss
    step(1, 0, 0, 0);
    idle(5);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    idle(2);

    // long pausa, then miss on the expiry tick
    for (int k = 0; k < 20; k++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    idle(11);
    step(0, 0, 1, 0);
    idle(3);

    // J1 5 - J2 3, late par_valido ignored
    step(1, 0, 0, 0);
    hit(5);
    step(0, 0, 1, 0);
    hit(3);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    idle(20);

    // replay to a 4-4 tie
    step(1, 0, 0, 0);
    hit(4);
    step(0, 0, 1, 0);
    hit(4);
    idle(3);

    // async reset mid-game with puntos_j1 = 2
    step(1, 0, 0, 0);
    hit(2);
    idle(6);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 report("async_reset", actual(), zero);
    repeat (2) @(posedge clk);
    #1 report("reset_no_pulse", actual(), zero);
    model_reset();
    @(negedge clk) rst = 1'b1;
    step(1, 0, 0, 0);
    idle(14);

    // randomized play
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0, 0);
    @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, need 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
